// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM port arbiter: FSM encoding, master IDs and byte-enable constants.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_CLR_HOLD = 2'd1,
        ST_CLR_WAIT = 2'd2
    } arb_state_t;

    localparam logic       MID_M0  = 1'b0;
    localparam logic       MID_M1  = 1'b1;
    localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/bram_addr_window.sv
// Rebases a requester byte address by the runtime memory offset and checks window/alignment.
module bram_addr_window #(
    parameter int MEM_DEPTH = 4096
) (
    input  logic [31:0] i_addr,
    input  logic [31:0] i_mem_offset,
    output logic [31:0] o_word_addr,
    output logic        o_in_window
);

    localparam logic [31:0] WIN_BYTES = 32'(4 * MEM_DEPTH);

    logic [31:0] w_off;

    // Subtraction wraps mod 2^32, so an address below the base is caught by the compare instead.
    assign w_off       = i_addr - i_mem_offset;
    assign o_word_addr = w_off & ~32'h3;
    assign o_in_window = (i_addr >= i_mem_offset) && (w_off < WIN_BYTES) && (i_addr[1:0] == 2'b00);

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-master arbiter in front of a single-port BRAM with offset rebasing and rstb-driven clear.
// Define BRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority M1 over M0.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int MEM_DEPTH = 4096,
    parameter int CLEAR_MIN = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_offset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    input  logic        clear_req,
    output logic        clear_done,
    output logic        bram_clkb,
    output logic        bram_enb,
    output logic        bram_rstb,
    output logic [3:0]  bram_web,
    output logic [31:0] bram_addrb,
    output logic [31:0] bram_dinb,
    input  logic [31:0] bram_doutb,
    input  logic        bram_rstb_busy,
    output arb_state_t  o_dbg_state
);

    // Handshake: mN_req is held until mN_gnt, which is combinational in the accepting cycle;
    // mN_rvalid follows exactly one cycle later and mN_err qualifies that response.

    arb_state_t  r_state, w_state_nxt;
    logic [7:0]  r_hold_cnt, w_hold_cnt_nxt;
    logic        r_rv0, r_rv1, r_err, r_clear_done, w_clear_done_nxt;
    logic        w_run, w_gnt0, w_gnt1, w_any, w_in_win;
    logic [31:0] w_waddr0, w_waddr1;
    logic        w_win0, w_win1;

    bram_addr_window #(.MEM_DEPTH(MEM_DEPTH)) u_win0 (
        .i_addr(m0_addr), .i_mem_offset(mem_offset), .o_word_addr(w_waddr0), .o_in_window(w_win0)
    );
    bram_addr_window #(.MEM_DEPTH(MEM_DEPTH)) u_win1 (
        .i_addr(m1_addr), .i_mem_offset(mem_offset), .o_word_addr(w_waddr1), .o_in_window(w_win1)
    );

    // Grants are forced low while reset is asserted even though requests may already be high.
    assign w_run = reset_n && (r_state == ST_RUN);

`ifdef BRAM_ARB_RR_EN
    logic r_prio;
    assign w_gnt0 = w_run && m0_req && (!m1_req || (r_prio == MID_M0));
    assign w_gnt1 = w_run && m1_req && (!m0_req || (r_prio == MID_M1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_prio <= MID_M0;
        else if (w_gnt0) r_prio <= MID_M1;
        else if (w_gnt1) r_prio <= MID_M0;
    end
`else
    assign w_gnt1 = w_run && m1_req;
    assign w_gnt0 = w_run && m0_req && !m1_req;
`endif

    assign w_any    = w_gnt0 || w_gnt1;
    assign w_in_win = w_gnt1 ? w_win1 : w_win0;

    assign m0_gnt     = w_gnt0;
    assign m1_gnt     = w_gnt1;
    assign bram_clkb  = clk;
    assign bram_enb   = w_any && w_in_win;
    assign bram_addrb = w_any ? (w_gnt1 ? w_waddr1 : w_waddr0) : 32'h0;
    assign bram_dinb  = w_any ? (w_gnt1 ? m1_wdata : m0_wdata) : 32'h0;
    assign bram_web   = !bram_enb ? BE_NONE :
                        w_gnt1 ? (m1_we ? m1_be : BE_NONE) : (m0_we ? m0_be : BE_NONE);
    assign bram_rstb  = (r_state == ST_CLR_HOLD);

    assign m0_rvalid  = r_rv0;
    assign m1_rvalid  = r_rv1;
    assign m0_err     = r_rv0 && r_err;
    assign m1_err     = r_rv1 && r_err;
    assign m0_rdata   = (r_rv0 && !r_err) ? bram_doutb : 32'h0;
    assign m1_rdata   = (r_rv1 && !r_err) ? bram_doutb : 32'h0;
    assign clear_done = r_clear_done;
    assign o_dbg_state = r_state;

    always_comb begin
        w_state_nxt      = r_state;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_clear_done_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (clear_req) begin
                    w_state_nxt    = ST_CLR_HOLD;
                    w_hold_cnt_nxt = 8'd0;
                end
            end
            ST_CLR_HOLD: begin
                if (r_hold_cnt >= 8'(CLEAR_MIN - 1)) w_state_nxt = ST_CLR_WAIT;
                else w_hold_cnt_nxt = r_hold_cnt + 8'd1;
            end
            ST_CLR_WAIT: begin
                if (!bram_rstb_busy) begin
                    w_state_nxt      = ST_RUN;
                    w_clear_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_RUN;
            r_hold_cnt   <= 8'd0;
            r_rv0        <= 1'b0;
            r_rv1        <= 1'b0;
            r_err        <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_rv0        <= w_gnt0;
            r_rv1        <= w_gnt1;
            r_err        <= w_any && !w_in_win;
            r_clear_done <= w_clear_done_nxt;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: BRAM model, directed scenarios with literal expectations, randomized traffic
// checked every cycle against a behavioural model of the arbiter.
module tb_bram_port_arbiter;
    import bram_arb_pkg::*;

    localparam int DEPTH   = 16;
    localparam int CLR_MIN = 2;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [31:0] mem_offset = 32'h0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        clear_req = 0, clear_done;
    logic        bram_clkb, bram_enb, bram_rstb, bram_rstb_busy = 0;
    logic [3:0]  bram_web;
    logic [31:0] bram_addrb, bram_dinb, bram_doutb = 32'h0;
    arb_state_t  dbg_state;

    int checks = 0, errors = 0;

    bram_port_arbiter #(.MEM_DEPTH(DEPTH), .CLEAR_MIN(CLR_MIN)) dut (
        .clk(clk), .reset_n(reset_n), .mem_offset(mem_offset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .clear_req(clear_req), .clear_done(clear_done),
        .bram_clkb(bram_clkb), .bram_enb(bram_enb), .bram_rstb(bram_rstb), .bram_web(bram_web),
        .bram_addrb(bram_addrb), .bram_dinb(bram_dinb), .bram_doutb(bram_doutb),
        .bram_rstb_busy(bram_rstb_busy), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [3:0] be,
                                             input logic [31:0] d);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        return w;
    endfunction

    // ---------------- BRAM model (write-first, 1-cycle read, rstb clears) ----------------
    logic [31:0] bram_mem [DEPTH] = '{default: 32'h0};

    always @(posedge clk) begin
        if (bram_rstb) begin
            for (int i = 0; i < DEPTH; i++) bram_mem[i] <= 32'h0;
            bram_doutb <= 32'h0;
        end else if (bram_enb) begin
            bram_mem[int'(bram_addrb[31:2]) % DEPTH] <=
                merge_be(bram_mem[int'(bram_addrb[31:2]) % DEPTH], bram_web, bram_dinb);
            bram_doutb <= merge_be(bram_mem[int'(bram_addrb[31:2]) % DEPTH], bram_web, bram_dinb);
        end
    end

    // ---------------- behavioural reference model + per-cycle compare ----------------
    logic [31:0] shadow [DEPTH] = '{default: 32'h0};
    int          m_hold = 0;        // rstb cycles still owed in the current clear
    bit          m_wait = 0;        // clear issued, waiting for busy to drop
    bit          m_done = 0;
    bit          pend_v = 0, pend_err = 0;
    int          pend_m = 0;
    logic [31:0] pend_data = 32'h0;
    int          rr_last = 1;       // M0 wins the first tie

    task automatic model_step();
        int          win, idx;
        bit          running, next_done, iw;
        logic [31:0] a, off, wd, w;
        logic [3:0]  be;
        logic        we;
        chk1("clkb_fwd", bram_clkb, clk);
        if (!reset_n) begin
            chk1("rst_m0_gnt", m0_gnt, 1'b0);     chk1("rst_m1_gnt", m1_gnt, 1'b0);
            chk1("rst_m0_rvalid", m0_rvalid, 1'b0); chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
            chk1("rst_m0_err", m0_err, 1'b0);     chk1("rst_m1_err", m1_err, 1'b0);
            chk32("rst_m0_rdata", m0_rdata, 32'h0); chk32("rst_m1_rdata", m1_rdata, 32'h0);
            chk1("rst_enb", bram_enb, 1'b0);      chk1("rst_rstb", bram_rstb, 1'b0);
            chk32("rst_web", {28'h0, bram_web}, 32'h0); chk1("rst_clear_done", clear_done, 1'b0);
            m_hold = 0; m_wait = 0; m_done = 0; pend_v = 0; rr_last = 1;
            return;
        end
        running = (m_hold == 0) && !m_wait;
        chk1("rstb", bram_rstb, m_hold > 0);
        chk1("clear_done", clear_done, m_done);
        win = -1;
        if (running) begin
            if (m0_req && m1_req) begin
`ifdef BRAM_ARB_RR_EN
                win = (rr_last == 0) ? 1 : 0;
`else
                win = 1;
`endif
            end else if (m1_req) win = 1;
            else if (m0_req) win = 0;
        end
        chk1("m0_gnt", m0_gnt, win == 0);
        chk1("m1_gnt", m1_gnt, win == 1);
        chk1("m0_rvalid", m0_rvalid, pend_v && pend_m == 0);
        chk1("m1_rvalid", m1_rvalid, pend_v && pend_m == 1);
        if (pend_v && pend_m == 0) begin
            chk1("m0_err", m0_err, pend_err); chk32("m0_rdata", m0_rdata, pend_data);
        end
        if (pend_v && pend_m == 1) begin
            chk1("m1_err", m1_err, pend_err); chk32("m1_rdata", m1_rdata, pend_data);
        end
        pend_v = 0;
        if (win >= 0) begin
            a  = (win == 1) ? m1_addr : m0_addr;
            we = (win == 1) ? m1_we : m0_we;
            be = (win == 1) ? m1_be : m0_be;
            wd = (win == 1) ? m1_wdata : m0_wdata;
            off = a - mem_offset;
            iw  = (a >= mem_offset) && (off < 32'(4 * DEPTH)) && (a % 4 == 0);
            chk1("enb", bram_enb, iw);
            if (iw) begin
                idx = int'(off / 4);
                w   = we ? merge_be(shadow[idx], be, wd) : shadow[idx];
                shadow[idx] = w;
                chk32("addrb", bram_addrb, 32'(idx * 4));
                chk32("web", {28'h0, bram_web}, {28'h0, (we ? be : 4'h0)});
                chk32("dinb", bram_dinb, wd);
                pend_data = w; pend_err = 0;
            end else begin
                pend_data = 32'h0; pend_err = 1;
            end
            pend_v = 1; pend_m = win; rr_last = win;
        end else begin
            chk1("enb_idle", bram_enb, 1'b0);
        end
        next_done = 0;
        if (running) begin
            if (clear_req) begin
                m_hold = CLR_MIN;
                for (int i = 0; i < DEPTH; i++) shadow[i] = 32'h0;
            end
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_wait = 1;
        end else if (m_wait && !bram_rstb_busy) begin
            m_wait = 0; next_done = 1;
        end
        m_done = next_done;
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int m, input logic r, input logic [31:0] a, input logic we,
                           input logic [3:0] be, input logic [31:0] d);
        if (m == 0) begin m0_req = r; m0_addr = a; m0_we = we; m0_be = be; m0_wdata = d; end
        else        begin m1_req = r; m1_addr = a; m1_we = we; m1_be = be; m1_wdata = d; end
    endtask

    task automatic access(input int m, input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output logic en_g, output logic [31:0] ab_g, output logic [3:0] wb_g);
        bit got = 0;
        en_g = 0; ab_g = 0; wb_g = 0;
        @(posedge clk); #1;
        set_req(m, 1'b1, a, we, be, d);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_gnt : m1_gnt) begin
                got = 1; en_g = bram_enb; ab_g = bram_addrb; wb_g = bram_web;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL grant_timeout m%0d: got no gnt, expected gnt within 40 cycles", m);
        end
        @(posedge clk); #1;
        if (m == 0) m0_req = 0; else m1_req = 0;
        @(negedge clk);
        chk1("rvalid_after_gnt", (m == 0) ? m0_rvalid : m1_rvalid, 1'b1);
        rd = (m == 0) ? m0_rdata : m1_rdata;
        er = (m == 0) ? m0_err : m1_err;
    endtask

    function automatic logic [31:0] rand_addr();
        int k = $urandom_range(0, 9);
        if (k < 7)       return mem_offset + 32'(4 * $urandom_range(0, DEPTH - 1));
        else if (k == 7) return mem_offset + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
        else if (k == 8) return mem_offset - 32'(4 * $urandom_range(1, 4));
        else             return mem_offset + 32'(4 * DEPTH + 4 * $urandom_range(0, 4));
    endfunction

    task automatic new_req(input int m);
        set_req(m, 1'b1, rand_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd, ab, base;
        logic        er, en;
        logic [3:0]  wb;
        int          cnt, gseen, dcnt, winner;
        bit          got, g0, g1;

        // Reset with a request already pending: nothing may be granted.
        set_req(1, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk1("reset_gnt", m1_gnt, 1'b0);
        chk1("reset_rvalid", m0_rvalid, 1'b0);
        chk1("reset_rstb", bram_rstb, 1'b0);
        chk32("reset_state", 32'(dbg_state), 32'(ST_RUN));
        @(posedge clk); #1;
        m1_req = 0;
        base = 32'h1000_0000;
        mem_offset = base;
        reset_n = 1;

        // Full-word write.
        access(0, base + 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, rd, er, en, ab, wb);
        chk32("t1_addrb", ab, 32'h10);
        chk32("t1_web", {28'h0, wb}, 32'hF);
        chk32("t1_rdata", rd, 32'hDEADBEEF);
        chk1("t1_err", er, 1'b0);

        // Simultaneous reads: M1 first, M0 the following cycle.
        @(posedge clk); #1;
        set_req(0, 1'b1, base + 32'h10, 1'b0, 4'h0, 32'h0);
        set_req(1, 1'b1, base + 32'h14, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk1("t2_m1_first", m1_gnt, 1'b1);
        chk1("t2_m0_waits", m0_gnt, 1'b0);
        @(posedge clk); #1;
        m1_req = 0;
        @(negedge clk);
        chk1("t2_m0_second", m0_gnt, 1'b1);
        chk32("t2_m1_rdata", m1_rdata, 32'h0);
        @(posedge clk); #1;
        m0_req = 0;
        @(negedge clk);
        chk32("t2_m0_rdata", m0_rdata, 32'hDEADBEEF);

        // Continuous contention.
        @(posedge clk); #1;
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            winner = m1_gnt ? 1 : 0;
`ifdef BRAM_ARB_RR_EN
            chk32("tie_winner", 32'(winner), (i % 2 == 0) ? 32'd1 : 32'd0);
`else
            chk32("tie_winner", 32'(winner), 32'd1);
`endif
        end
        @(posedge clk); #1;
        m0_req = 0; m1_req = 0;

        // Window and alignment edges.
        access(0, base - 32'h4, 1'b0, 4'h0, 32'h0, rd, er, en, ab, wb);
        chk1("t3_below_en", en, 1'b0); chk1("t3_below_err", er, 1'b1); chk32("t3_below_rdata", rd, 32'h0);
        access(0, base + 32'(4 * DEPTH), 1'b0, 4'h0, 32'h0, rd, er, en, ab, wb);
        chk1("t3_above_en", en, 1'b0); chk1("t3_above_err", er, 1'b1); chk32("t3_above_rdata", rd, 32'h0);
        access(0, base + 32'h2, 1'b0, 4'h0, 32'h0, rd, er, en, ab, wb);
        chk1("t3_misalign_err", er, 1'b1);
        access(1, base + 32'(4 * DEPTH - 4), 1'b0, 4'h0, 32'h0, rd, er, en, ab, wb);
        chk1("t3_last_word_err", er, 1'b0);
        chk32("t3_last_word_addrb", ab, 32'(4 * DEPTH - 4));

        // Byte-lane merge.
        access(1, base + 32'h20, 1'b1, 4'hF, 32'h11223344, rd, er, en, ab, wb);
        access(0, base + 32'h20, 1'b1, 4'b0010, 32'h0000AB00, rd, er, en, ab, wb);
        chk32("t5_merged", rd, 32'h1122AB44);

        // Clear while M0 waits.
        @(posedge clk); #1;
        clear_req = 1;
        @(posedge clk); #1;
        clear_req = 0;
        bram_rstb_busy = 1;
        set_req(0, 1'b1, base + 32'h10, 1'b0, 4'h0, 32'h0);
        cnt = 0; gseen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_gnt) gseen++;
            if (bram_rstb) cnt++;
            else if (cnt > 0) break;
        end
        chk32("t4_rstb_cycles", 32'(cnt), 32'(CLR_MIN));
        chk32("t4_gnt_during_clear", 32'(gseen), 32'd0);
        repeat (3) @(posedge clk);
        #1 bram_rstb_busy = 0;
        dcnt = 0; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (clear_done) dcnt++;
            if (m0_gnt) got = 1;
        end
        chk1("t4_granted_after", got, 1'b1);
        @(posedge clk); #1;
        m0_req = 0;
        @(negedge clk);
        chk32("t4_cleared_rdata", m0_rdata, 32'h0);
        repeat (3) begin
            @(negedge clk);
            if (clear_done) dcnt++;
        end
        chk32("t4_done_pulses", 32'(dcnt), 32'd1);

        // Reset right after a grant drops the response.
        access(1, base + 32'h20, 1'b1, 4'hF, 32'h1122AB44, rd, er, en, ab, wb);
        @(posedge clk); #1;
        set_req(0, 1'b1, base + 32'h20, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk1("t6_gnt", m0_gnt, 1'b1);
        @(posedge clk); #1;
        m0_req = 0; reset_n = 0;
        @(negedge clk);
        chk1("t6_no_rvalid", m0_rvalid, 1'b0);
        chk32("t6_rdata", m0_rdata, 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1;
        access(0, base + 32'h20, 1'b0, 4'h0, 32'h0, rd, er, en, ab, wb);
        chk32("t6_clean_read", rd, 32'h1122AB44);
        chk1("t6_clean_err", er, 1'b0);

        // Randomized traffic, clears and busy.
        @(posedge clk); #1;
        mem_offset = 32'($urandom_range(64, 32'h7FFF_0000)) & ~32'h3;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            g0 = m0_gnt; g1 = m1_gnt;
            @(posedge clk); #1;
            if (g0 || !m0_req) begin
                if ($urandom_range(0, 2) != 0) new_req(0); else m0_req = 0;
            end
            if (g1 || !m1_req) begin
                if ($urandom_range(0, 2) != 0) new_req(1); else m1_req = 0;
            end
            clear_req = ($urandom_range(0, 79) == 0);
            bram_rstb_busy = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk); #1;
        m0_req = 0; m1_req = 0; clear_req = 0; bram_rstb_busy = 0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
